// File: rtl/msi_bus_pkg.sv
// Shared constants for the MSI bus buffering blocks: request-ID width and the
// default geometry of the banked FIFO.
`ifndef rbusD_width
`define rbusD_width 16
`endif

package msi_bus_pkg;
  localparam int REQ_ID_W        = 10;
  localparam int DEF_DATA_W      = 512;
  localparam int DEF_BANKS       = 2;
  localparam int DEF_DEPTH       = 32;
  localparam int DEF_STALL_LEVEL = 24;
endpackage

// File: rtl/adder.sv
// Generic adder cells used for pointer and occupancy arithmetic.
module adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);
  assign sum = a + b;
endmodule

module adder_inc #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] sum
);
  assign sum = a + W'(1);
endmodule

// File: rtl/msi_bus_fifo_ram.sv
// Shared 1R/1W storage for all FIFO banks. The read address is registered, so
// rdata shows the entry addressed by the last enabled read.
module msi_bus_fifo_ram #(
  parameter int W  = 8,
  parameter int N  = 64,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0]  mem [N];
  logic [AW-1:0] raddr_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) raddr_q <= raddr;
  end

  assign rdata = mem[raddr_q];
endmodule

// File: rtl/msi_bus_banked_fifo.sv
// Banked FIFO: BANKS independent circular queues sharing one RAM, with a
// one-cycle pop latency, per-bank almost-full flags and sticky error flags.
`ifndef rbusD_width
`define rbusD_width 16
`endif

module msi_bus_banked_fifo
  import msi_bus_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SIG_W       = `rbusD_width,
  parameter int BANKS       = DEF_BANKS,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int STALL_LEVEL = DEF_STALL_LEVEL,
  localparam int BW = $clog2(BANKS),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [BW-1:0]       wr_bank,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [SIG_W-1:0]    wr_sig,
  input  logic [9:0]          wr_src_req,
  input  logic [9:0]          wr_dst_req,
  input  logic                rd_en,
  input  logic [BW-1:0]       rd_bank,
  input  logic                stall,
  output logic [DATA_W-1:0]   rd_data,
  output logic [SIG_W-1:0]    rd_sig,
  output logic [9:0]          rd_src_req,
  output logic [9:0]          rd_dst_req,
  output logic                rd_valid,
  output logic [BANKS-1:0]    doStall,
  output logic [BANKS*CW-1:0] count,
  output logic                err_ovf,
  output logic                err_udf
);
  localparam int PW = CW - 1;
  localparam int AW = BW + PW;
  localparam int EW = DATA_W + SIG_W + 2 * REQ_ID_W;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(STALL_LEVEL);

  logic [PW-1:0] wr_ptr     [BANKS];
  logic [PW-1:0] rd_ptr     [BANKS];
  logic [CW-1:0] cnt        [BANKS];
  logic [PW-1:0] wr_ptr_inc [BANKS];
  logic [PW-1:0] rd_ptr_inc [BANKS];
  logic [CW-1:0] cnt_next   [BANKS];
  logic [CW-1:0] delta      [BANKS];
  logic [BANKS-1:0] push_v, pop_v;

  // Handshake: there is no backpressure on either side. A push is accepted when
  // its bank has room (or is full but popped in the same cycle); a pop is
  // accepted when stall is low and its bank is non-empty. Anything else is
  // dropped, flagged and leaves the queues untouched.
  logic pop_try, pop_ok, push_ok;
  assign pop_try = rd_en & ~stall;
  assign pop_ok  = pop_try & (cnt[rd_bank] != '0);
  assign push_ok = wr_en & ((cnt[wr_bank] != FULL_CNT) | (pop_ok & (wr_bank == rd_bank)));

  always_comb begin
    for (int b = 0; b < BANKS; b++) begin
      push_v[b] = push_ok && (wr_bank == BW'(b));
      pop_v[b]  = pop_ok && (rd_bank == BW'(b));
      delta[b]  = '0;
      if (push_v[b] && !pop_v[b]) delta[b] = CW'(1);
      else if (pop_v[b] && !push_v[b]) delta[b] = '1;
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    adder_inc #(.W(PW)) u_wr_inc (.a(wr_ptr[b]), .sum(wr_ptr_inc[b]));
    adder_inc #(.W(PW)) u_rd_inc (.a(rd_ptr[b]), .sum(rd_ptr_inc[b]));
    adder     #(.W(CW)) u_cnt    (.a(cnt[b]), .b(delta[b]), .sum(cnt_next[b]));
    assign count[b*CW +: CW] = cnt[b];
    assign doStall[b]        = (cnt[b] >= STALL_CNT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < BANKS; b++) begin
        wr_ptr[b] <= '0;
        rd_ptr[b] <= '0;
        cnt[b]    <= '0;
      end
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      for (int b = 0; b < BANKS; b++) begin
        if (push_v[b]) wr_ptr[b] <= wr_ptr_inc[b];
        if (pop_v[b])  rd_ptr[b] <= rd_ptr_inc[b];
        cnt[b] <= cnt_next[b];
      end
      err_ovf <= err_ovf | (wr_en & ~push_ok);
      err_udf <= err_udf | (pop_try & (cnt[rd_bank] == '0));
    end
  end

  // Writes land in the RAM one cycle late so that a full bank pushed and popped
  // in the same cycle still reads the old entry out of the shared slot.
  logic          stage_v;
  logic [AW-1:0] stage_addr;
  logic [EW-1:0] stage_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stage_v <= 1'b0;
    else      stage_v <= push_ok;
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      stage_addr <= {wr_bank, wr_ptr[wr_bank]};
      stage_data <= {wr_data, wr_sig, wr_src_req, wr_dst_req};
    end
  end

  logic [EW-1:0] ram_q;

  msi_bus_fifo_ram #(.W(EW), .N(BANKS * DEPTH)) u_ram (
    .clk   (clk),
    .we    (stage_v),
    .waddr (stage_addr),
    .wdata (stage_data),
    .re    (pop_ok),
    .raddr ({rd_bank, rd_ptr[rd_bank]}),
    .rdata (ram_q)
  );

  // hold_q keeps the last popped entry visible once rd_valid drops.
  logic [EW-1:0] hold_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      hold_q   <= '0;
    end else begin
      rd_valid <= pop_ok;
      if (rd_valid) hold_q <= ram_q;
    end
  end

  assign {rd_data, rd_sig, rd_src_req, rd_dst_req} = rd_valid ? ram_q : hold_q;
endmodule
